cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer (controller) for the 8-bit accumulator CPU.
- Drives the load/enable strobes of the datapath: the IR, AC and PC registers, the address mux, and the memory read/write enables.
- Sits directly upstream of the datapath registers. Its ld_ir and ld_ac outputs feed their load inputs.
- Consumes the opcode field of the instruction register and the ALU zero flag.

Parameters:
- OPC_W, 3, opcode width. Fixed encoding below; other values unsupported.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- opcode  in  OPC_W  opcode from the instruction register. Stable from IDLE to STORE.
- zero  in  1  accumulator-zero flag from the ALU.
- sel  out  1  address mux select: 1 = PC, 0 = IR operand.
- rd  out  1  memory read enable.
- ld_ir  out  1  instruction register load.
- inc_pc  out  1  PC increment.
- ld_pc  out  1  PC load (jump).
- ld_ac  out  1  accumulator load.
- wr  out  1  memory write strobe.
- data_e  out  1  AC-to-bus tristate enable.
- halt  out  1  CPU halted.
- phase  out  3  current phase, for debug and visibility.

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.
- State: 3-bit phase register. Phases in order:
  - INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3
  - OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7
- Phase advances by 1 every CLK. STORE wraps to INST_ADDR. One instruction = 8 cycles.
- Outputs are combinational decode of (phase, opcode, zero, halt flag). Any signal not listed for a phase is 0.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ & zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=(opcode==JMP); ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Halt:
  - At the OP_ADDR→OP_FETCH edge with opcode==HLT, an internal halt flag sets.
  - The phase then freezes at OP_FETCH. Only halt=1 is asserted; all strobes stay 0.
  - Halt persists until RST.
- Reset:
  - RST low asynchronously forces phase=INST_ADDR and clears the halt flag, including mid-instruction.
  - While RST is low: sel=1, all other strobes 0, halt=0, phase=0.
  - First advance occurs on the first CLK rising edge after RST deasserts.
- zero is sampled only in ALU_OP. Changes in other phases have no effect.
- opcode changes outside IDLE..STORE are ignored by design. Decode uses the live value, so IR must hold it.
- No two of wr/rd are ever simultaneously 1. Invariant: rd & wr == 0 in every phase.

Optional Feature:
- Macro: CPU_SEQ_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - Phase holds at INST_ADDR until step is sampled high on a CLK edge.
  - Then one full instruction runs and the sequencer returns to and holds at INST_ADDR.
  - step held high gives free-running operation.
  - Halt behaviour is unchanged.
- Undefined: no step port. The sequencer free-runs as above.

Decomposition:
- Shared package cpu_pkg:
  - opcode enum (HLT..JMP) and OPC_W.
  - phase enum (INST_ADDR..STORE) and its width.
  - ALUOP membership helper function.
- No sub-module needed: phase counter and decode live in one module.
- The datapath registers remain separate instances driven by these strobes.

Test Plan:
- Reset then 8 clocks with opcode=ADD → phase 0..7 then 0. ld_ir=1 in phases 2 and 3 only; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 in phase 7 only; inc_pc=1 in phase 4 only.
- opcode=STO → wr=1 only in phase 7, data_e=1 in phases 6 and 7, rd=0 in phases 5–7, ld_ac=0 throughout.
- opcode=SKZ:
  - zero=1 → inc_pc=1 in phases 4 and 6.
  - zero=0 → inc_pc=1 in phase 4 only.
- opcode=JMP → ld_pc=1 in phases 6 and 7, inc_pc=1 in phases 4 and 7.
- opcode=HLT → halt=1 from phase 4. Phase stays 5 for 20 further clocks with all strobes 0. RST low then high → phase=0, halt=0.
- Assert RST low asynchronously at phase 6, between clock edges → phase=0 and sel=1 immediately; after release, phase=1 on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and phase encodings shared by the accumulator CPU controller
package cpu_pkg;
   localparam int OPC_W = 3;
   localparam int PH_W  = 3;
   typedef enum logic [OPC_W-1:0] {
      HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
      XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
   } opcode_t;
   typedef enum logic [PH_W-1:0] {
      INST_ADDR = 3'd0, INST_FETCH = 3'd1, INST_LOAD = 3'd2, IDLE  = 3'd3,
      OP_ADDR   = 3'd4, OP_FETCH   = 3'd5, ALU_OP    = 3'd6, STORE = 3'd7
   } phase_t;
   // Opcodes that read an operand from memory and load the accumulator
   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase controller driving the accumulator CPU datapath strobes.
// Optional macro CPU_SEQ_STEP_EN adds i_step: hold at INST_ADDR until step is seen high.
module cpu_sequencer
   import cpu_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
`ifdef CPU_SEQ_STEP_EN
   input  logic             i_step,
`endif
   input  logic [OPC_W-1:0] i_opcode,
   input  logic             i_zero,
   output logic             o_sel,
   output logic             o_rd,
   output logic             o_ld_ir,
   output logic             o_inc_pc,
   output logic             o_ld_pc,
   output logic             o_ld_ac,
   output logic             o_wr,
   output logic             o_data_e,
   output logic             o_halt,
   output logic [PH_W-1:0]  o_phase
);
   phase_t  r_phase;
   logic    r_halt;
   phase_t  w_phase_nxt;
   logic    w_halt_nxt;
   logic    w_advance;
   logic    w_alu;
   opcode_t w_op;

   assign w_op    = opcode_t'(i_opcode);
   assign w_alu   = is_aluop(w_op);
   assign o_phase = r_phase;
`ifdef CPU_SEQ_STEP_EN
   assign w_advance = (r_phase != INST_ADDR) || i_step;
`else
   assign w_advance = 1'b1;
`endif

   // Phase register and sticky halt flag; once halted the phase stays frozen until reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase <= INST_ADDR;
         r_halt  <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
         r_halt  <= w_halt_nxt;
      end
   end

   // Next phase and combinational strobe decode of phase, opcode, zero and halt flag
   always_comb begin
      w_phase_nxt = r_phase;
      w_halt_nxt  = r_halt;
      o_sel       = 1'b0;
      o_rd        = 1'b0;
      o_ld_ir     = 1'b0;
      o_inc_pc    = 1'b0;
      o_ld_pc     = 1'b0;
      o_ld_ac     = 1'b0;
      o_wr        = 1'b0;
      o_data_e    = 1'b0;
      o_halt      = r_halt;
      if (!r_halt) begin
         if (w_advance)
            w_phase_nxt = phase_t'(r_phase + 3'd1);
         case (r_phase)
            INST_ADDR: o_sel = 1'b1;
            INST_FETCH: begin
               o_sel = 1'b1;
               o_rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               o_sel   = 1'b1;
               o_rd    = 1'b1;
               o_ld_ir = 1'b1;
            end
            OP_ADDR: begin
               o_inc_pc   = 1'b1;
               o_halt     = (w_op == HLT);
               w_halt_nxt = (w_op == HLT);
            end
            OP_FETCH: o_rd = w_alu;
            ALU_OP: begin
               o_rd     = w_alu;
               o_inc_pc = (w_op == SKZ) && i_zero;
               o_ld_pc  = (w_op == JMP);
               o_data_e = (w_op == STO);
            end
            default: begin
               o_rd     = w_alu;
               o_ld_ac  = w_alu;
               o_inc_pc = (w_op == JMP);
               o_ld_pc  = (w_op == JMP);
               o_wr     = (w_op == STO);
               o_data_e = (w_op == STO);
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of phase sequencing, per-opcode strobes, halt and async reset
module tb_cpu_sequencer;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       zero = 1'b0;
   logic [2:0] opcode = 3'd2;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;
   logic [8:0] vec;
   int         errors = 0;
   int         checks = 0;

   // Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
   localparam logic [8:0] V_RST  = 9'b100000000;
   localparam logic [8:0] V_P1   = 9'b110000000;
   localparam logic [8:0] V_P23  = 9'b111000000;
   localparam logic [8:0] V_INC  = 9'b000100000;
   localparam logic [8:0] V_NONE = 9'b000000000;
   localparam logic [8:0] V_HALT = 9'b000000001;

`ifdef CPU_SEQ_STEP_EN
   logic step = 1'b1;
`endif

   cpu_sequencer dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
`ifdef CPU_SEQ_STEP_EN
      .i_step   (step),
`endif
      .i_opcode (opcode),
      .i_zero   (zero),
      .o_sel    (sel),
      .o_rd     (rd),
      .o_ld_ir  (ld_ir),
      .o_inc_pc (inc_pc),
      .o_ld_pc  (ld_pc),
      .o_ld_ac  (ld_ac),
      .o_wr     (wr),
      .o_data_e (data_e),
      .o_halt   (halt),
      .o_phase  (phase)
   );

   assign vec = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2:0] ph, input logic [8:0] ev);
      checks++;
      assert (phase === ph) else begin
         errors++;
         $error("FAIL %s phase got=%0d exp=%0d", tag, phase, ph);
      end
      checks++;
      assert (vec === ev) else begin
         errors++;
         $error("FAIL %s strobes got=%b exp=%b", tag, vec, ev);
      end
      checks++;
      assert ((rd & wr) === 1'b0) else begin
         errors++;
         $error("FAIL %s rd_wr_overlap got=%b exp=0", tag, rd & wr);
      end
   endtask

   // Entered at a negedge in phase 0; leaves at the negedge of the following phase 0
   task automatic run_instr(input string tag, input logic [2:0] opc, input logic z,
                            input logic [8:0] e4, input logic [8:0] e5,
                            input logic [8:0] e6, input logic [8:0] e7);
      logic [8:0] e [8];
      e = '{V_RST, V_P1, V_P23, V_P23, e4, e5, e6, e7};
      opcode = opc;
      zero   = z;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_p%0d", tag, i), i[2:0], e[i]);
         @(negedge clk);
      end
      check($sformatf("%s_wrap", tag), 3'd0, V_RST);
   endtask

   initial begin
      #12;
      check("reset_hold", 3'd0, V_RST);
      repeat (3) @(negedge clk);
      check("reset_clocked", 3'd0, V_RST);
      rst_n = 1'b1;
      run_instr("add",     3'd2, 1'b1, V_INC, 9'b010000000, 9'b010000000, 9'b010001000);
      run_instr("sto",     3'd6, 1'b0, V_INC, V_NONE, 9'b000000010, 9'b000000110);
      run_instr("skz_z1",  3'd1, 1'b1, V_INC, V_NONE, V_INC, V_NONE);
      run_instr("skz_z0",  3'd1, 1'b0, V_INC, V_NONE, V_NONE, V_NONE);
      run_instr("jmp",     3'd7, 1'b0, V_INC, V_NONE, 9'b000010000, 9'b000110000);
      run_instr("lda",     3'd5, 1'b0, V_INC, 9'b010000000, 9'b010000000, 9'b010001000);
      opcode = 3'd2;
      repeat (6) @(negedge clk);
      check("pre_async", 3'd6, 9'b010000000);
      #2 rst_n = 1'b0;
      #1 check("async_rst", 3'd0, V_RST);
      @(negedge clk);
      check("async_hold", 3'd0, V_RST);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("first_edge", 3'd1, V_P1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      opcode = 3'd0;
      check("hlt_p0", 3'd0, V_RST);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hlt_p%0d", i), i[2:0], (i == 4) ? 9'b000100001 : (i == 1) ? V_P1 : V_P23);
      end
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         check($sformatf("halted_%0d", i), 3'd5, V_HALT);
      end
      rst_n = 1'b0;
      #1 check("halt_clear", 3'd0, V_RST);
      @(negedge clk);
      rst_n = 1'b1;
      opcode = 3'd3;
      @(negedge clk);
      check("post_halt_run", 3'd1, V_P1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
